// File: rtl/wb_trace_checker_pkg.sv
// Shared types for the write-back trace checker.
//   chk_state_e : checker FSM states
//   REG_ADDR_W / REG_W / ENTRY_W : field widths of one expected-write entry
//   make_entry  : packs {destination register, data} into one table word
package wb_trace_checker_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned ENTRY_W    = REG_ADDR_W + REG_W;

  typedef enum logic [2:0] {
    CHK_IDLE = 3'd0,
    CHK_RUN  = 3'd1,
    CHK_PASS = 3'd2,
    CHK_FAIL = 3'd3,
    CHK_TMO  = 3'd4
  } chk_state_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [REG_ADDR_W-1:0] rd,
                                                     input logic [REG_W-1:0]      data);
    return {rd, data};
  endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// Expected-write table: DEPTH x 37 bits, synchronous write, asynchronous read.
// Not reset, so contents survive rst.
//   clk   : clock
//   we    : write strobe
//   waddr : write index
//   wdata : {reg, data} entry to store
//   raddr : read index
//   rdata : entry at raddr (combinational)
module wb_trace_ram
  import wb_trace_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_checker.sv
// Observer on the write-back port: compares each accepted GPR write, in order,
// against a preloaded table and ends in PASS, FAIL (mismatch captured) or TMO.
//   clk, rst                           : clock, synchronous active-high reset
//   wb_wreg_i, wb_wd_i, wb_wdata_i     : live write-back port
//   exp_we_i, exp_addr_i, exp_reg_i,
//   exp_data_i                         : table load (ignored while RUN)
//   exp_len_i, start_i                 : entry count (clamped to DEPTH) and start pulse
//   busy_o, done_o, pass_o, fail_o,
//   timeout_o                          : registered status flags
//   match_cnt_o                        : entries matched so far
//   err_idx_o, err_reg_o, err_data_o   : first mismatch capture
//   cycle_cnt_o                        : saturating count of RUN cycles
module wb_trace_checker
  import wb_trace_checker_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned CNT_W     = 16,
  parameter bit          IGNORE_R0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_wreg_i,
  input  logic [REG_ADDR_W-1:0] wb_wd_i,
  input  logic [REG_W-1:0]      wb_wdata_i,
  input  logic                  exp_we_i,
  input  logic [IDX_W-1:0]      exp_addr_i,
  input  logic [REG_ADDR_W-1:0] exp_reg_i,
  input  logic [REG_W-1:0]      exp_data_i,
  input  logic [IDX_W:0]        exp_len_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [IDX_W:0]        match_cnt_o,
  output logic [IDX_W-1:0]      err_idx_o,
  output logic [REG_ADDR_W-1:0] err_reg_o,
  output logic [REG_W-1:0]      err_data_o,
  output logic [CNT_W-1:0]      cycle_cnt_o
);

  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]    DEPTH_LEN = (IDX_W + 1)'(DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  chk_state_e            state, state_n;
  logic [IDX_W:0]        len, len_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [IDX_W:0]        match_cnt, match_cnt_n;
  logic [IDLE_W-1:0]     idle_cnt, idle_cnt_n;
  logic [CNT_W-1:0]      cycle_cnt, cycle_cnt_n;
  logic [IDX_W-1:0]      err_idx, err_idx_n;
  logic [REG_ADDR_W-1:0] err_reg, err_reg_n;
  logic [REG_W-1:0]      err_data, err_data_n;
  logic [ENTRY_W-1:0]    cur_entry;
  logic                  accept;
  logic                  hit;

  // Table is frozen while a check is in progress.
  wb_trace_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (exp_we_i && (state != CHK_RUN)),
    .waddr (exp_addr_i),
    .wdata (make_entry(exp_reg_i, exp_data_i)),
    .raddr (idx),
    .rdata (cur_entry)
  );

  assign accept = (state == CHK_RUN) && wb_wreg_i && !(IGNORE_R0 && (wb_wd_i == '0));
  assign hit    = (cur_entry == make_entry(wb_wd_i, wb_wdata_i));

  always_comb begin
    state_n     = state;
    len_n       = len;
    idx_n       = idx;
    match_cnt_n = match_cnt;
    idle_cnt_n  = idle_cnt;
    cycle_cnt_n = cycle_cnt;
    err_idx_n   = err_idx;
    err_reg_n   = err_reg;
    err_data_n  = err_data;
    case (state)
      CHK_IDLE, CHK_PASS, CHK_FAIL, CHK_TMO: begin
        if (start_i) begin
          len_n       = (exp_len_i > DEPTH_LEN) ? DEPTH_LEN : exp_len_i;
          idx_n       = '0;
          match_cnt_n = '0;
          idle_cnt_n  = '0;
          cycle_cnt_n = '0;
          err_idx_n   = '0;
          err_reg_n   = '0;
          err_data_n  = '0;
          state_n     = (exp_len_i == '0) ? CHK_PASS : CHK_RUN;
        end
      end
      CHK_RUN: begin
        if (cycle_cnt != '1) begin
          cycle_cnt_n = cycle_cnt + CNT_W'(1);
        end
        if (accept) begin
          if (hit) begin
            idx_n       = idx + IDX_W'(1);
            match_cnt_n = match_cnt + (IDX_W + 1)'(1);
            idle_cnt_n  = '0;
            if ({1'b0, idx} == len - (IDX_W + 1)'(1)) begin
              state_n = CHK_PASS;
            end
          end else begin
            err_idx_n  = idx;
            err_reg_n  = wb_wd_i;
            err_data_n = wb_wdata_i;
            state_n    = CHK_FAIL;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state_n = CHK_TMO;
        end else begin
          idle_cnt_n = idle_cnt + IDLE_W'(1);
        end
      end
      default: state_n = CHK_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CHK_IDLE;
      len       <= '0;
      idx       <= '0;
      match_cnt <= '0;
      idle_cnt  <= '0;
      cycle_cnt <= '0;
      err_idx   <= '0;
      err_reg   <= '0;
      err_data  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      idx       <= idx_n;
      match_cnt <= match_cnt_n;
      idle_cnt  <= idle_cnt_n;
      cycle_cnt <= cycle_cnt_n;
      err_idx   <= err_idx_n;
      err_reg   <= err_reg_n;
      err_data  <= err_data_n;
      busy_o    <= (state_n == CHK_RUN);
      done_o    <= (state_n == CHK_PASS) || (state_n == CHK_FAIL) || (state_n == CHK_TMO);
      pass_o    <= (state_n == CHK_PASS);
      fail_o    <= (state_n == CHK_FAIL);
      timeout_o <= (state_n == CHK_TMO);
    end
  end

  assign match_cnt_o = match_cnt;
  assign err_idx_o   = err_idx;
  assign err_reg_o   = err_reg;
  assign err_data_o  = err_data;
  assign cycle_cnt_o = cycle_cnt;

endmodule
